// File: rtl/dispatch_pkg.sv
// Shared definitions for the dispatch_8 one-entry dispatch stage.
// Holds the stage state type, channel/select/counter widths and a small
// helper that turns a channel select into a one-hot valid vector.
package dispatch_pkg;

    localparam int CH_NUM = 8;
    localparam int SEL_W  = 3;
    localparam int CNT_W  = 16;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // One-hot decode of a channel select.
    function automatic logic [CH_NUM-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        logic [CH_NUM-1:0] vec;
        vec      = {CH_NUM{1'b0}};
        vec[sel] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/dispatch_8.sv
// dispatch_8: one-entry registered dispatch stage feeding an 8-way demux.
// A beat accepted on the upstream side is held in a single register and
// presented to the channel chosen either explicitly (s_dest_i) or by an
// internal round-robin pointer (s_rr_i=1).
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   s_valid_i/s_ready_o/s_data_i/s_dest_i/s_rr_i   upstream beat + routing
//   select_o, m_data_o                             demux select and payload
//   m_valid_o[7:0], m_ready_i[7:0]                 per-channel handshake
//   beat_cnt_o                                     accepted-beat count (wraps)
module dispatch_8
    import dispatch_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic [SEL_W-1:0]      s_dest_i,
    input  logic                  s_rr_i,
    output logic [SEL_W-1:0]      select_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic [CH_NUM-1:0]     m_valid_o,
    input  logic [CH_NUM-1:0]     m_ready_i,
    output logic [CNT_W-1:0]      beat_cnt_o
);

    state_t                  state_r;
    state_t                  state_s;
    logic [SEL_W-1:0]        select_r;
    logic [DATA_WIDTH-1:0]   data_r;
    logic [CH_NUM-1:0]       m_valid_r;
    logic [SEL_W-1:0]        rr_ptr_r;
    logic [CNT_W-1:0]        beat_cnt_r;
    logic                    sel_ready_s;
    logic                    accept_s;
    logic                    deliver_s;
    logic [SEL_W-1:0]        dest_s;

    // Only the ready of the currently selected channel matters; the rest are ignored.
    assign sel_ready_s = m_ready_i[select_r];
    assign s_ready_o   = (state_r == EMPTY) || sel_ready_s;
    assign accept_s    = s_valid_i && s_ready_o;
    assign deliver_s   = (state_r == FULL) && sel_ready_s;
    assign dest_s      = s_rr_i ? rr_ptr_r : s_dest_i;

    assign select_o    = select_r;
    assign m_data_o    = data_r;
    assign m_valid_o   = m_valid_r;
    assign beat_cnt_o  = beat_cnt_r;

    // Next-state logic for the one-entry stage.
    always_comb begin
        state_s = state_r;
        case (state_r)
            EMPTY: begin
                if (accept_s) begin
                    state_s = FULL;
                end else begin
                    state_s = EMPTY;
                end
            end
            FULL: begin
                // Accept together with deliver keeps the slot occupied.
                if (deliver_s && !accept_s) begin
                    state_s = EMPTY;
                end else begin
                    state_s = FULL;
                end
            end
            default: begin
                state_s = EMPTY;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= EMPTY;
        end else begin
            state_r <= state_s;
        end
    end

    // Payload, select and one-hot valid; payload/select hold when not reloaded.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_r    <= {DATA_WIDTH{1'b0}};
            select_r  <= {SEL_W{1'b0}};
            m_valid_r <= {CH_NUM{1'b0}};
        end else if (accept_s) begin
            data_r    <= s_data_i;
            select_r  <= dest_s;
            m_valid_r <= sel_onehot(dest_s);
        end else if (deliver_s) begin
            m_valid_r <= {CH_NUM{1'b0}};
        end else begin
            m_valid_r <= m_valid_r;
        end
    end

    // Round-robin pointer advances only on round-robin accepts; beat counter on every accept.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_r   <= {SEL_W{1'b0}};
            beat_cnt_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            beat_cnt_r <= beat_cnt_r + CNT_W'(1'b1);
            if (s_rr_i) begin
                rr_ptr_r <= rr_ptr_r + SEL_W'(1'b1);
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
        end else begin
            rr_ptr_r   <= rr_ptr_r;
            beat_cnt_r <= beat_cnt_r;
        end
    end

endmodule

// File: tb/tb_dispatch_8.sv
// Directed self-checking bench for dispatch_8.
module tb_dispatch_8;

    logic        clk_i;
    logic        rst_i;
    logic        s_valid_i;
    logic        s_ready_o;
    logic [7:0]  s_data_i;
    logic [2:0]  s_dest_i;
    logic        s_rr_i;
    logic [2:0]  select_o;
    logic [7:0]  m_data_o;
    logic [7:0]  m_valid_o;
    logic [7:0]  m_ready_i;
    logic [15:0] beat_cnt_o;

    int checks;
    int errors;
    int deliveries;

    dispatch_8 #(.DATA_WIDTH(8)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .s_valid_i  (s_valid_i),
        .s_ready_o  (s_ready_o),
        .s_data_i   (s_data_i),
        .s_dest_i   (s_dest_i),
        .s_rr_i     (s_rr_i),
        .select_o   (select_o),
        .m_data_o   (m_data_o),
        .m_valid_o  (m_valid_o),
        .m_ready_i  (m_ready_i),
        .beat_cnt_o (beat_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Count beats leaving on the selected channel (pre-edge values).
    always @(posedge clk_i) begin
        if (!rst_i && ((m_valid_o & m_ready_i) != 8'h00)) begin
            deliveries = deliveries + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        deliveries = 0;
        rst_i      = 1'b1;
        s_valid_i  = 1'b0;
        s_data_i   = 8'h00;
        s_dest_i   = 3'd0;
        s_rr_i     = 1'b0;
        m_ready_i  = 8'h00;
        #1;
        chk("rst_valid", {24'h0, m_valid_o}, 32'h0);
        chk("rst_sel", {29'h0, select_o}, 32'h0);
        chk("rst_data", {24'h0, m_data_o}, 32'h0);
        chk("rst_cnt", {16'h0, beat_cnt_o}, 32'h0);
        chk("rst_ready", {31'h0, s_ready_o}, 32'h1);

        // Valid during reset must not be accepted.
        s_valid_i = 1'b1;
        s_data_i  = 8'h99;
        tick();
        chk("rst_noacc_cnt", {16'h0, beat_cnt_o}, 32'h0);
        chk("rst_noacc_valid", {24'h0, m_valid_o}, 32'h0);
        rst_i = 1'b0;

        // Explicit destination 5, data A5, no downstream ready.
        s_valid_i = 1'b1;
        s_rr_i    = 1'b0;
        s_dest_i  = 3'd5;
        s_data_i  = 8'hA5;
        m_ready_i = 8'h00;
        tick();
        s_valid_i = 1'b0;
        chk("exp_valid", {24'h0, m_valid_o}, 32'h20);
        chk("exp_data", {24'h0, m_data_o}, 32'hA5);
        chk("exp_sel", {29'h0, select_o}, 32'h5);
        chk("exp_cnt", {16'h0, beat_cnt_o}, 32'h1);
        chk("exp_ready_low", {31'h0, s_ready_o}, 32'h0);

        // Deliver it; payload holds while empty.
        m_ready_i = 8'h20;
        tick();
        chk("exp_drain_valid", {24'h0, m_valid_o}, 32'h0);
        chk("empty_hold_data", {24'h0, m_data_o}, 32'hA5);

        // Backpressure on channel 3.
        s_valid_i = 1'b1;
        s_dest_i  = 3'd3;
        s_data_i  = 8'h3C;
        m_ready_i = 8'hF7;
        tick();
        s_dest_i = 3'd1;
        s_data_i = 8'h77;
        for (int i = 0; i < 4; i++) begin
            chk("bp_ready", {31'h0, s_ready_o}, 32'h0);
            tick();
            chk("bp_data", {24'h0, m_data_o}, 32'h3C);
            chk("bp_sel", {29'h0, select_o}, 32'h3);
            chk("bp_valid", {24'h0, m_valid_o}, 32'h08);
            chk("bp_cnt", {16'h0, beat_cnt_o}, 32'h2);
        end
        s_valid_i = 1'b0;
        m_ready_i = 8'hFF;
        #1;
        chk("bp_release_ready", {31'h0, s_ready_o}, 32'h1);
        tick();
        chk("bp_delivered", {24'h0, m_valid_o}, 32'h0);
        chk("bp_cnt_after", {16'h0, beat_cnt_o}, 32'h2);

        // Round robin: rr_ptr still 0 since explicit beats left it alone.
        s_valid_i = 1'b1;
        s_rr_i    = 1'b1;
        s_dest_i  = 3'd6;
        m_ready_i = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            s_data_i = 8'(8'h40 + i);
            #1;
            chk("rr_ready", {31'h0, s_ready_o}, 32'h1);
            tick();
            chk("rr_sel", {29'h0, select_o}, 32'(i % 8));
            chk("rr_data", {24'h0, m_data_o}, 32'(8'h40 + i));
            chk("rr_valid", {24'h0, m_valid_o}, 32'(8'h01 << (i % 8)));
            chk("rr_cnt", {16'h0, beat_cnt_o}, 32'(3 + i));
        end
        s_valid_i = 1'b0;
        tick();
        chk("rr_drain_valid", {24'h0, m_valid_o}, 32'h0);
        chk("rr_final_cnt", {16'h0, beat_cnt_o}, 32'd12);

        // Simultaneous accept and deliver.
        s_valid_i = 1'b1;
        s_rr_i    = 1'b0;
        s_dest_i  = 3'd2;
        s_data_i  = 8'h11;
        m_ready_i = 8'h00;
        tick();
        chk("sim_first_valid", {24'h0, m_valid_o}, 32'h04);
        s_dest_i  = 3'd6;
        s_data_i  = 8'h22;
        m_ready_i = 8'h04;
        #1;
        chk("sim_ready", {31'h0, s_ready_o}, 32'h1);
        tick();
        s_valid_i = 1'b0;
        m_ready_i = 8'h00;
        chk("sim_valid", {24'h0, m_valid_o}, 32'h40);
        chk("sim_data", {24'h0, m_data_o}, 32'h22);
        chk("sim_sel", {29'h0, select_o}, 32'h6);
        tick();
        chk("sim_hold_data", {24'h0, m_data_o}, 32'h22);
        m_ready_i = 8'h40;
        tick();
        chk("sim_drained", {24'h0, m_valid_o}, 32'h0);
        chk("sim_cnt", {16'h0, beat_cnt_o}, 32'd14);
        chk("sb_deliveries", 32'(deliveries), 32'd14);

        // Reset while holding a beat.
        s_valid_i = 1'b1;
        s_dest_i  = 3'd4;
        s_data_i  = 8'h5A;
        m_ready_i = 8'h00;
        tick();
        s_valid_i = 1'b0;
        chk("mid_full_valid", {24'h0, m_valid_o}, 32'h10);
        rst_i = 1'b1;
        #1;
        chk("mid_rst_valid", {24'h0, m_valid_o}, 32'h0);
        chk("mid_rst_cnt", {16'h0, beat_cnt_o}, 32'h0);
        chk("mid_rst_sel", {29'h0, select_o}, 32'h0);
        chk("mid_rst_data", {24'h0, m_data_o}, 32'h0);
        chk("mid_rst_ready", {31'h0, s_ready_o}, 32'h1);
        m_ready_i = 8'hFF;
        tick();
        chk("mid_rst_nodeliver", 32'(deliveries), 32'd14);
        rst_i = 1'b0;

        // Counter wrap: 65535 accepts, then one more.
        s_valid_i = 1'b1;
        s_rr_i    = 1'b1;
        m_ready_i = 8'hFF;
        for (int i = 0; i < 65535; i++) begin
            tick();
        end
        chk("wrap_pre", {16'h0, beat_cnt_o}, 32'hFFFF);
        tick();
        chk("wrap_zero", {16'h0, beat_cnt_o}, 32'h0);
        s_valid_i = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dispatch_8.md
DISPATCH_8 -- requirements
Module: dispatch_8

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the payload width in bits.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port s_valid_i, input, 1 bit: the upstream beat is valid.
REQ-005 SHALL have port s_ready_o, output, 1 bit: the block can accept a beat.
REQ-006 SHALL have port s_data_i, input, DATA_WIDTH bits: the upstream payload.
REQ-007 SHALL have port s_dest_i, input, 3 bits: the explicit destination channel.
REQ-008 SHALL have port s_rr_i, input, 1 bit: 1 selects round-robin destination; 0 selects s_dest_i.
REQ-009 SHALL have port select_o, output, 3 bits: the channel select for the downstream 8-way demux.
REQ-010 SHALL have port m_data_o, output, DATA_WIDTH bits: the registered payload for the downstream demux.
REQ-011 SHALL have port m_valid_o, output, 8 bits: one-hot valid per channel.
REQ-012 SHALL have port m_ready_i, input, 8 bits: per-channel ready.
REQ-013 SHALL have port beat_cnt_o, output, 16 bits: accepted-beat count, wrapping.

Function
REQ-014 SHALL be a one-entry registered stage with states EMPTY and FULL.
REQ-015 Handshake: a beat SHALL be accepted when s_valid_i && s_ready_o, and delivered when m_valid_o[select_o] && m_ready_i[select_o].
REQ-016 s_ready_o SHALL equal (state==EMPTY) || m_ready_i[select_o], combinationally; this allows 1 beat/cycle throughput.
REQ-017 Transitions:
- EMPTY -> FULL on accept.
- FULL -> FULL on simultaneous accept and deliver; data and select reload.
- FULL -> EMPTY on deliver without accept.
- FULL holds while not delivered.
REQ-018 Latency SHALL be 1 cycle from accept to m_valid_o.
REQ-019 On accept, the beat's destination SHALL be rr_ptr when s_rr_i=1, else s_dest_i.
REQ-020 On accept, m_data_o and select_o SHALL load s_data_i and the chosen destination.
REQ-021 m_valid_o SHALL be one-hot at bit select_o when FULL, and 8'h00 when EMPTY.
REQ-022 While FULL and not delivered, m_data_o and select_o SHALL be held stable.
REQ-023 rr_ptr (3 bits) SHALL increment by 1 only on an accept with s_rr_i=1, wrapping 7 -> 0.
REQ-024 An explicit-destination accept SHALL leave rr_ptr unchanged.
REQ-025 beat_cnt_o SHALL increment by 1 on every accept, wrapping 16'hFFFF -> 16'h0000.
REQ-026 m_ready_i bits for channels other than select_o SHALL be ignored.
REQ-027 When EMPTY, m_data_o SHALL hold its last value; it SHALL never be driven to Z.

Reset
REQ-028 While rst_i=1, the block SHALL immediately force:
- state = EMPTY
- m_valid_o = 8'h00, select_o = 3'h0, m_data_o = 0
- rr_ptr = 0, beat_cnt_o = 16'h0000
REQ-029 Reset asserted mid-transfer SHALL discard the held beat with no delivery.
REQ-030 s_ready_o SHALL be 1 during reset (state EMPTY); accepts SHALL take effect only after rst_i deasserts.

Structure
REQ-031 Shared package dispatch_pkg SHALL hold:
- the state enum type (EMPTY, FULL)
- the constants CH_NUM=8 and SEL_W=3
- the constant CNT_W=16
REQ-032 The block SHALL be one module with no sub-modules.
REQ-033 Its select_o/m_data_o outputs SHALL connect directly to the 8-way demux's select and data inputs.

Verification
REQ-034 Reset: assert rst_i mid-FULL -> m_valid_o=8'h00, beat_cnt_o=0, select_o=0 within the same cycle.
REQ-035 Round-robin: 10 beats with s_rr_i=1 and all m_ready_i=8'hFF -> select_o sequence 0..7,0,1; one beat per cycle; beat_cnt_o=10.
REQ-036 Explicit: s_rr_i=0, s_dest_i=5, data 8'hA5 -> m_valid_o=8'h20, m_data_o=8'hA5 one cycle later; rr_ptr unchanged.
REQ-037 Backpressure: select_o=3, m_ready_i=8'hF7 for 4 cycles ->
- s_ready_o=0 throughout
- data held stable
- delivery on the cycle bit 3 rises
REQ-038 Simultaneous: FULL, deliver and accept in the same cycle -> stays FULL with the new data/select; no beat lost or duplicated (scoreboard).
REQ-039 Wrap: preload 65535 accepts (or force) then 1 accept -> beat_cnt_o=16'h0000.
